// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding select and load-use stall unit
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int NSTAGE = 3,
  parameter int NPORT  = 2,
  localparam int SW    = $clog2(NSTAGE + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [NPORT*REG_AW-1:0] id_rs,
  input  logic [NPORT-1:0]        id_rs_en,
  input  logic [REG_AW-1:0]       id_rd,
  input  logic                    id_we,
  input  logic                    id_load,
  input  logic                    hold,
  input  logic                    flush,
  output logic [NPORT*SW-1:0]     fwd_sel,
  output logic                    stall,
  output logic [15:0]             stall_cnt
);

  // In-flight destination record, index 0 is the youngest (EX) stage
  logic [NSTAGE-1:0]             we_q, we_d;
  logic [NSTAGE-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [NSTAGE-1:0]             load_q, load_d;
  logic [15:0]                   stall_cnt_q, stall_cnt_d;

  logic                          load_use;

  // Per-port bypass select; scanning oldest to youngest lets the youngest producer win
  always_comb begin
    fwd_sel  = '0;
    load_use = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      for (int s = NSTAGE - 1; s >= 0; s--) begin
        if (id_rs_en[p] && we_q[s] && (rd_q[s] != '0) &&
            (rd_q[s] == id_rs[p*REG_AW +: REG_AW])) begin
          fwd_sel[p*SW +: SW] = SW'(s + 1);
          if (s == 0 && load_q[0]) begin
            load_use = 1'b1;
          end
        end
      end
    end
    stall = id_valid & ~flush & load_use;
  end

  // Next-state: freeze on hold, bubble on flush/stall, otherwise admit the ID instruction
  always_comb begin
    we_d        = we_q;
    rd_d        = rd_q;
    load_d      = load_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      for (int s = 1; s < NSTAGE; s++) begin
        we_d[s]   = we_q[s-1];
        rd_d[s]   = rd_q[s-1];
        load_d[s] = load_q[s-1];
      end
      if (flush || stall) begin
        we_d[0]   = 1'b0;
        rd_d[0]   = '0;
        load_d[0] = 1'b0;
      end else begin
        we_d[0]   = id_valid & id_we;
        rd_d[0]   = id_rd;
        load_d[0] = id_valid & id_load;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  // Stage record and stall counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= '0;
      rd_q        <= '0;
      load_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      we_q        <= we_d;
      rd_q        <= rd_d;
      load_q      <= load_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_en;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        id_load;
  logic        hold;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  int          checks;
  int          failures;
  logic [15:0] exp_cnt;

  fwd_hazard_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rs_en  (id_rs_en),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .id_load   (id_load),
    .hold      (hold),
    .flush     (flush),
    .fwd_sel   (fwd_sel),
    .stall     (stall),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [4:0] rs0, input logic en0, input logic [4:0] rs1, input logic en1);
    id_valid = v;
    id_rd    = rd;
    id_we    = we;
    id_load  = ld;
    id_rs    = {rs1, rs0};
    id_rs_en = {en1, en0};
    hold     = 1'b0;
    flush    = 1'b0;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
    tick();
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset: sel=%0h stall=%0b cnt=%0h expected 0/0/0", fwd_sel, stall, stall_cnt);
    end
    #2 rst_n = 1'b1;
    exp_cnt = 16'd0;
    drain();
  endtask

  task automatic test_forward_age();
    drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    checks++;
    if (fwd_sel[1:0] !== 2'd1 || stall !== 1'b0) begin
      failures++;
      $display("FAIL fwd_age1: sel0=%0d stall=%0b expected 1/0", fwd_sel[1:0], stall);
    end
    tick();
    id_valid = 1'b0;
    #1;
    checks++;
    if (fwd_sel[1:0] !== 2'd2) begin
      failures++;
      $display("FAIL fwd_age2: sel0=%0d expected 2", fwd_sel[1:0]);
    end
    tick();
    checks++;
    if (fwd_sel[1:0] !== 2'd3) begin
      failures++;
      $display("FAIL fwd_age3: sel0=%0d expected 3", fwd_sel[1:0]);
    end
    tick();
    checks++;
    if (fwd_sel[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL fwd_age_gone: sel0=%0d expected 0", fwd_sel[1:0]);
    end
    drain();
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    checks++;
    if (fwd_sel[3:2] !== 2'd1 || fwd_sel[1:0] !== 2'd0) begin
      failures++;
      $display("FAIL youngest: sel1=%0d sel0=%0d expected 1/0", fwd_sel[3:2], fwd_sel[1:0]);
    end
    drain();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1);
    checks++;
    if (stall !== 1'b1 || fwd_sel !== 4'b0101 || stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL load_use_stall: stall=%0b sel=%0h cnt=%0h expected 1/5/%0h", stall, fwd_sel, stall_cnt, exp_cnt);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (stall !== 1'b0 || fwd_sel !== 4'b1010 || stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL load_use_after: stall=%0b sel=%0h cnt=%0h expected 0/a/%0h", stall, fwd_sel, stall_cnt, exp_cnt);
    end
    tick();
    checks++;
    if (stall_cnt !== exp_cnt || fwd_sel[1:0] !== 2'd3) begin
      failures++;
      $display("FAIL load_use_drain: cnt=%0h sel0=%0d expected %0h/3", stall_cnt, fwd_sel[1:0], exp_cnt);
    end
    drain();
  endtask

  task automatic test_r0_and_disabled();
    drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_match: sel=%0h stall=%0b expected 0/0", fwd_sel, stall);
    end
    drain();
    drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0);
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rs_disabled: sel=%0h stall=%0b expected 0/0", fwd_sel, stall);
    end
    drain();
  endtask

  task automatic test_hold();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stall !== 1'b1 || fwd_sel[1:0] !== 2'd1 || stall_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL hold_%0d: stall=%0b sel0=%0d cnt=%0h expected 1/1/%0h", i, stall, fwd_sel[1:0], stall_cnt, exp_cnt);
      end
    end
    hold = 1'b0;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd2 || stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL hold_release: stall=%0b sel0=%0d cnt=%0h expected 0/2/%0h", stall, fwd_sel[1:0], stall_cnt, exp_cnt);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || fwd_sel[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL flush_stall: stall=%0b sel0=%0d expected 0/1", stall, fwd_sel[1:0]);
    end
    tick();
    flush    = 1'b0;
    id_valid = 1'b0;
    #1;
    checks++;
    if (fwd_sel[1:0] !== 2'd2 || stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL flush_bubble: sel0=%0d cnt=%0h expected 2/%0h", fwd_sel[1:0], stall_cnt, exp_cnt);
    end
    drain();
  endtask

  task automatic test_saturate();
    drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    tick();
    exp_cnt = 16'hFFFF;
    checks++;
    if (stall_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL saturate: cnt=%0h expected ffff", stall_cnt);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    checks++;
    if (stall !== 1'b1 || fwd_sel[1:0] !== 2'd1) begin
      failures++;
      $display("FAIL pre_reset: stall=%0b sel0=%0d expected 1/1", stall, fwd_sel[1:0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: sel=%0h stall=%0b cnt=%0h expected 0/0/0", fwd_sel, stall, stall_cnt);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (fwd_sel !== 4'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: sel=%0h stall=%0b expected 0/0", fwd_sel, stall);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_cnt  = 16'd0;
    rst_n    = 1'b0;
    test_reset();
    test_forward_age();
    test_youngest();
    test_load_use();
    test_r0_and_disabled();
    test_hold();
    test_flush();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined core. It generalises two-stage EX/MEM forwarding to NSTAGE tracked pipeline stages and NPORT source-operand ports. It keeps its own registered record of in-flight destination writes instead of taking them from pipeline registers. It also generates the load-use stall, inserts bubbles, and keeps a saturating stall counter. It sits beside the ID stage and drives the operand bypass muxes and the ID/IF hold logic.

## Interface
- REG_AW, 5: register-number width.
- NSTAGE, 3: tracked in-flight stages after ID (stage 0 = EX, 1 = MEM, 2 = WB); must be ≥ 2.
- NPORT, 2: number of source-operand ports.
- SW, $clog2(NSTAGE+1): select width, derived, not overridable.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NPORT*REG_AW  source register numbers; port p is bits [p*REG_AW +: REG_AW].
- id_rs_en  in  NPORT  port p actually reads its source.
- id_rd  in  REG_AW  destination of the ID instruction.
- id_we  in  1  ID instruction writes a register.
- id_load  in  1  ID instruction is a load (data available from stage 1 onward).
- hold  in  1  external pipeline freeze.
- flush  in  1  squash the ID instruction.
- fwd_sel  out  NPORT*SW  per-port bypass select: 0 = register file, k = result of stage k-1.
- stall  out  1  load-use stall request to IF/ID.
- stall_cnt  out  16  saturating count of stall cycles.

## Operation
- State: per stage s, registered {we[s], rd[s], load[s]}.
- Match: port p matches stage s when id_rs_en[p], we[s], rd[s] ≠ 0, and rd[s] == rs_p.
- fwd_sel[p] = s+1 for the lowest matching s (youngest producer wins), else 0. It is computed even when id_valid = 0.
- stall = id_valid & ~flush & (some port matches stage 0 with load[0] = 1). A load is the youngest match only in stage 0. A load in stage ≥ 1 is forwarded normally.
- Update priority at each rising edge: hold, then flush/stall, then normal.
  - hold = 1: all stage state and stall_cnt unchanged.
  - flush = 1 or stall = 1: stage 0 ← bubble {0, 0, 0}; stage s ← stage s-1 for s ≥ 1; the oldest stage drops.
  - normal: stage 0 ← {id_valid & id_we, id_rd, id_valid & id_load}; remaining stages shift as above.
- Destination r0 never enters the match, even when we = 1.
- stall_cnt increments on each edge with stall = 1 and hold = 0. It saturates at 16'hFFFF and does not wrap.
- While stalled, the ID instruction stays in ID and is re-evaluated next cycle. The unit does not latch it.

## Timing
- fwd_sel and stall are purely combinational from inputs and stage state, with zero-cycle latency.
- A producer issued (unstalled) in cycle n is visible to a consumer in cycle n+1 with fwd_sel = 1, and in n+k with fwd_sel = k for k ≤ NSTAGE. From n+NSTAGE+1 it is gone.
- A load-use stall lasts exactly one cycle when hold = 0. The load then sits in stage 1 and the consumer gets fwd_sel = 2.
- When hold = 1, stall is held steady for as long as hold stays asserted.
- Reset (rst_n = 0, asynchronous, no clock needed) clears all we/rd/load and stall_cnt to 0. fwd_sel = 0 and stall = 0 follow immediately.
- Deassertion of rst_n is assumed synchronous to clk upstream.

## Test plan
- Issue rd=5, we=1 at cycle n, then rs0=5, rs_en0=1 at n+1 → fwd_sel port0 = 1, stall = 0. Idle cycles follow → sel 2, then 3, then 0.
- Producers rd=9 at cycle n and rd=9 again at n+1, consumer rs1=9 at n+2 → port1 sel = 1 (youngest wins), not 2.
- Load rd=7 at n, consumer rs0=7 at n+1 → stall = 1 and stall_cnt 0→1. At n+2: stall = 0, port0 sel = 2, stage 0 holds a bubble.
- Producer rd=0 with we=1, consumer rs0=0; and rd=4 with rs_en0=0 → fwd_sel = 0, stall = 0 in both cases.
- Load-use with hold=1 for 3 cycles → stall stays 1, stall_cnt unchanged, stage state frozen. Same load-use with flush=1 → stall = 0 and a bubble is inserted. Force stall_cnt to 16'hFFFF → it stays at 16'hFFFF.
- Pull rst_n low mid-stream between clock edges → fwd_sel = 0, stall = 0, stall_cnt = 0 immediately. After release, a previously tracked rd gives no match.
